ndp_job_controller: RTL and testbench

- Sequences one matrix-tile job through the NDP unit (activation and weight feed, flush, completion wait, result drain).
- Accepts a job command over a valid/ready handshake and issues per-cycle read addresses to the activation and weight SRAMs.
- Drives the NDP unit's in_done_flag and datapath clear, then streams result rows out over a valid/ready handshake.
- Sits between the host command queue / SRAMs and the NDP unit instance.

---
 rtl/ndp_ctrl_defs.sv | 25 ++
 rtl/ndp_addr_gen.sv | 73 +++++++
 rtl/ndp_job_controller.sv | 142 ++++++++++++++
 tb/tb_ndp_job_controller.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ndp_ctrl_defs.sv
// Shared definitions for the NDP job controller: state encodings, default
// widths and a ceiling-log2 helper for sizing index vectors.
package ndp_ctrl_defs;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_FEED      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_K_BITS    = 10;
  localparam int DEF_RES_ROWS  = 4;

  // Ceiling log2, never below 1 so the result can always size a vector.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/ndp_addr_gen.sv
// Activation/weight read-address generator: latches the job bases and length,
// then walks a beat counter through the FEED phase, raising the read enable on
// the first k beats only. Addresses wrap modulo 2^ADDR_BITS.
module ndp_addr_gen
  import ndp_ctrl_defs::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int K_BITS    = DEF_K_BITS,
  parameter int MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [K_BITS-1:0]    cmd_k,
  input  logic [ADDR_BITS-1:0] cmd_a_base,
  input  logic [ADDR_BITS-1:0] cmd_b_base,
  input  logic                 feed_start,
  input  logic                 feed_active,
  output logic                 feed_last,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_a_addr,
  output logic [ADDR_BITS-1:0] mem_b_addr
);

  // One extra bit so k plus the read latency never overflows.
  localparam int CNT_BITS = K_BITS + 1;

  logic [K_BITS-1:0]    k_q;
  logic [ADDR_BITS-1:0] a_base_q;
  logic [ADDR_BITS-1:0] b_base_q;
  logic [CNT_BITS-1:0]  beat_q;
  logic [CNT_BITS-1:0]  beat_nxt;
  logic [CNT_BITS-1:0]  last_beat;
  logic [ADDR_BITS-1:0] beat_off;

  // Beat presented in the next cycle and the final FEED beat index.
  always_comb begin
    beat_nxt  = feed_start ? '0 : beat_q + CNT_BITS'(1);
    beat_off  = ADDR_BITS'(beat_nxt);
    last_beat = {1'b0, k_q} + CNT_BITS'(MEM_LAT - 1);
  end

  assign feed_last = feed_active && (beat_q == last_beat);

  // Latch the command, then register beat, read enable and both addresses.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q        <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      beat_q     <= '0;
      mem_rd_en  <= 1'b0;
      mem_a_addr <= '0;
      mem_b_addr <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (load) begin
        k_q      <= cmd_k;
        a_base_q <= cmd_a_base;
        b_base_q <= cmd_b_base;
      end
      if (feed_start || feed_active) begin
        beat_q     <= beat_nxt;
        mem_rd_en  <= (beat_nxt < {1'b0, k_q});
        mem_a_addr <= a_base_q + beat_off;
        mem_b_addr <= b_base_q + beat_off;
      end else begin
        mem_rd_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ndp_job_controller.sv
// Sequences one matrix-tile job through the NDP unit: accept command, clear
// the datapath, feed A/B words, wait for calc_done (with timeout), then drain
// the result rows over a valid/ready handshake. All outputs are registered.
module ndp_job_controller
  import ndp_ctrl_defs::*;
#(
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int K_BITS         = DEF_K_BITS,
  parameter int MEM_LAT        = 1,
  parameter int RES_ROWS       = DEF_RES_ROWS,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [K_BITS-1:0]            cmd_k,
  input  logic [ADDR_BITS-1:0]         cmd_a_base,
  input  logic [ADDR_BITS-1:0]         cmd_b_base,
  output logic                         mem_rd_en,
  output logic [ADDR_BITS-1:0]         mem_a_addr,
  output logic [ADDR_BITS-1:0]         mem_b_addr,
  output logic                         ndp_clear,
  output logic                         ndp_in_done_flag,
  input  logic                         ndp_calc_done,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [clog2(RES_ROWS)-1:0]   res_row,
  output logic                         res_last,
  output logic                         job_done,
  output logic                         busy,
  output logic                         err_cmd,
  output logic                         err_timeout
);

  localparam int ROW_BITS = clog2(RES_ROWS);
  localparam int TO_BITS  = clog2(TIMEOUT_CYCLES);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(RES_ROWS - 1);
  localparam logic [TO_BITS-1:0]  TO_LAST  = TO_BITS'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [TO_BITS-1:0]   to_cnt_q, to_cnt_d;
  logic [ROW_BITS-1:0]  res_row_d;
  logic cmd_ready_d, busy_d, ndp_clear_d, in_done_d, res_valid_d, res_last_d;
  logic job_done_d, err_cmd_d, err_timeout_d;

  logic cmd_fire, accept, reject, res_fire, row_last, timeout_hit, feed_last;

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign accept      = cmd_fire && (cmd_k != '0);
  assign reject      = cmd_fire && (cmd_k == '0);
  assign res_fire    = res_valid && res_ready;
  assign row_last    = (res_row == LAST_ROW);
  assign timeout_hit = (to_cnt_q == TO_LAST);

  ndp_addr_gen #(
    .ADDR_BITS (ADDR_BITS),
    .K_BITS    (K_BITS),
    .MEM_LAT   (MEM_LAT)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .load        (accept),
    .cmd_k       (cmd_k),
    .cmd_a_base  (cmd_a_base),
    .cmd_b_base  (cmd_b_base),
    .feed_start  (state_q == ST_CLEAR),
    .feed_active (state_q == ST_FEED),
    .feed_last   (feed_last),
    .mem_rd_en   (mem_rd_en),
    .mem_a_addr  (mem_a_addr),
    .mem_b_addr  (mem_b_addr)
  );

  // State register plus the registered copies of every FSM output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      to_cnt_q         <= '0;
      cmd_ready        <= 1'b1;
      busy             <= 1'b0;
      ndp_clear        <= 1'b0;
      ndp_in_done_flag <= 1'b1;
      res_valid        <= 1'b0;
      res_row          <= '0;
      res_last         <= 1'b0;
      job_done         <= 1'b0;
      err_cmd          <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      state_q          <= state_d;
      to_cnt_q         <= to_cnt_d;
      cmd_ready        <= cmd_ready_d;
      busy             <= busy_d;
      ndp_clear        <= ndp_clear_d;
      ndp_in_done_flag <= in_done_d;
      res_valid        <= res_valid_d;
      res_row          <= res_row_d;
      res_last         <= res_last_d;
      job_done         <= job_done_d;
      err_cmd          <= err_cmd_d;
      err_timeout      <= err_timeout_d;
    end
  end

  // Next-state decode; in WAIT_DONE a done beats a same-cycle timeout.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (accept) state_d = ST_CLEAR;
      ST_CLEAR:     state_d = ST_FEED;
      ST_FEED:      if (feed_last) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (ndp_calc_done)    state_d = ST_DRAIN;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_DRAIN:     if (res_fire && row_last) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output decode: values the output registers take at the next edge.
  always_comb begin
    cmd_ready_d   = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    ndp_clear_d   = (state_d == ST_CLEAR);
    in_done_d     = (state_d != ST_FEED);
    res_valid_d   = (state_d == ST_DRAIN);
    res_row_d     = '0;
    if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN))
      res_row_d = res_fire ? res_row + ROW_BITS'(1) : res_row;
    res_last_d    = (state_d == ST_DRAIN) && (res_row_d == LAST_ROW);
    job_done_d    = (state_q == ST_DRAIN) && res_fire && row_last;
    err_cmd_d     = (state_q == ST_IDLE) && reject;
    err_timeout_d = (state_q == ST_WAIT_DONE) && !ndp_calc_done && timeout_hit;
    to_cnt_d      = '0;
    if ((state_q == ST_WAIT_DONE) && (state_d == ST_WAIT_DONE))
      to_cnt_d = to_cnt_q + TO_BITS'(1);
  end

endmodule

// File: tb/tb_ndp_job_controller.sv
// Self-checking bench for ndp_job_controller: expected addresses and result
// rows are queued when a job is issued and popped as the DUT produces them.
module tb_ndp_job_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_k;
  logic [9:0] cmd_a_base;
  logic [9:0] cmd_b_base;
  logic       mem_rd_en;
  logic [9:0] mem_a_addr;
  logic [9:0] mem_b_addr;
  logic       ndp_clear;
  logic       ndp_in_done_flag;
  logic       ndp_calc_done;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_row;
  logic       res_last;
  logic       job_done;
  logic       busy;
  logic       err_cmd;
  logic       err_timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0] exp_a_q[$];
  logic [9:0] exp_b_q[$];
  logic [1:0] exp_row_q[$];

  always #5 clk = ~clk;

  ndp_job_controller #(
    .ADDR_BITS      (10),
    .K_BITS         (10),
    .MEM_LAT        (1),
    .RES_ROWS       (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_k            (cmd_k),
    .cmd_a_base       (cmd_a_base),
    .cmd_b_base       (cmd_b_base),
    .mem_rd_en        (mem_rd_en),
    .mem_a_addr       (mem_a_addr),
    .mem_b_addr       (mem_b_addr),
    .ndp_clear        (ndp_clear),
    .ndp_in_done_flag (ndp_in_done_flag),
    .ndp_calc_done    (ndp_calc_done),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_row          (res_row),
    .res_last         (res_last),
    .job_done         (job_done),
    .busy             (busy),
    .err_cmd          (err_cmd),
    .err_timeout      (err_timeout)
  );

  // Flags in reset order: cmd_ready, in_done, rd_en, clear, res_valid,
  // res_last, job_done, busy, err_cmd, err_timeout.
  task automatic check_reset_values(input string name);
    tests_run++;
    if ({cmd_ready, ndp_in_done_flag, mem_rd_en, ndp_clear, res_valid, res_last,
         job_done, busy, err_cmd, err_timeout} !== 10'b11_0000_0000) begin
      tests_failed++;
      $display("FAIL %s flags: got %b want %b", name,
               {cmd_ready, ndp_in_done_flag, mem_rd_en, ndp_clear, res_valid, res_last,
                job_done, busy, err_cmd, err_timeout}, 10'b11_0000_0000);
    end
    tests_run++;
    if ({mem_a_addr, mem_b_addr, res_row} !== 22'd0) begin
      tests_failed++;
      $display("FAIL %s addr/row: got a=%h b=%h row=%0d want all 0", name,
               mem_a_addr, mem_b_addr, res_row);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_state");
    reset = 1'b0;
  endtask

  // Runs one job from command to job_done. rdy_pat gives res_ready per offered
  // row-cycle (bit 0 first) for rdy_len cycles, then res_ready stays high.
  task automatic run_job(input string name, input logic [9:0] k, input logic [9:0] a,
                         input logic [9:0] b, input int done_delay,
                         input logic [15:0] rdy_pat, input int rdy_len,
                         input bit drive_cmd, input bit hold_next,
                         input logic [9:0] nk, input logic [9:0] na, input logic [9:0] nb);
    logic [9:0] ea, eb;
    int cyc, low, rd, hs, rdy_idx, first_valid, wait_cnt, ready_bad, stray;
    bit feed_over, done;
    cyc = 1; low = 0; rd = 0; hs = 0; rdy_idx = 0; first_valid = -1;
    wait_cnt = 0; ready_bad = 0; stray = 0; feed_over = 1'b0; done = 1'b0;

    for (int i = 0; i < int'(k); i++) begin
      ea = a + 10'(i);
      eb = b + 10'(i);
      exp_a_q.push_back(ea);
      exp_b_q.push_back(eb);
    end
    for (int r = 0; r < 4; r++) exp_row_q.push_back(2'(r));

    if (drive_cmd) begin
      cmd_valid = 1'b1; cmd_k = k; cmd_a_base = a; cmd_b_base = b;
    end
    @(negedge clk);
    if (hold_next) begin
      cmd_valid = 1'b1; cmd_k = nk; cmd_a_base = na; cmd_b_base = nb;
    end else begin
      cmd_valid = 1'b0;
    end

    tests_run++;
    if ({ndp_clear, ndp_in_done_flag, busy, cmd_ready} !== 4'b1110) begin
      tests_failed++;
      $display("FAIL %s clear_cycle: got clr/idf/busy/rdy=%b want 1110", name,
               {ndp_clear, ndp_in_done_flag, busy, cmd_ready});
    end

    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (mem_rd_en) begin
        rd++;
        tests_run++;
        if (exp_a_q.size() == 0) begin
          tests_failed++;
          $display("FAIL %s extra_read: got a=%h b=%h want no read", name, mem_a_addr, mem_b_addr);
        end else begin
          ea = exp_a_q.pop_front();
          eb = exp_b_q.pop_front();
          if ({mem_a_addr, mem_b_addr} !== {ea, eb}) begin
            tests_failed++;
            $display("FAIL %s addr: got a=%h b=%h want a=%h b=%h", name,
                     mem_a_addr, mem_b_addr, ea, eb);
          end
        end
      end
      if (!ndp_in_done_flag) low++;
      if (cmd_ready && !job_done) ready_bad++;
      if (err_cmd || err_timeout || ndp_clear) stray++;
      if (low > 0 && ndp_in_done_flag && !feed_over) feed_over = 1'b1;

      if (res_valid) begin
        if (first_valid < 0) first_valid = cyc;
        tests_run++;
        if (exp_row_q.size() == 0) begin
          tests_failed++;
          $display("FAIL %s extra_row: got row=%0d want none", name, res_row);
        end else if ({res_row, res_last} !== {exp_row_q[0], exp_row_q[0] == 2'd3}) begin
          tests_failed++;
          $display("FAIL %s row: got row=%0d last=%b want row=%0d last=%b", name,
                   res_row, res_last, exp_row_q[0], exp_row_q[0] == 2'd3);
        end
        res_ready = (rdy_idx < rdy_len) ? rdy_pat[rdy_idx] : 1'b1;
        rdy_idx++;
        if (res_ready) begin
          if (exp_row_q.size() != 0) void'(exp_row_q.pop_front());
          hs++;
        end
      end else begin
        res_ready = 1'b0;
      end

      ndp_calc_done = 1'b0;
      if (feed_over && first_valid < 0) begin
        if (wait_cnt == done_delay) ndp_calc_done = 1'b1;
        wait_cnt++;
      end
      if (job_done) done = 1'b1;
    end
    ndp_calc_done = 1'b0;
    res_ready = 1'b0;

    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s job_done_timeout: got no job_done want one within 300 cycles", name);
    end
    tests_run++;
    if (low != int'(k) + 1) begin
      tests_failed++;
      $display("FAIL %s in_done_low: got %0d cycles want %0d", name, low, int'(k) + 1);
    end
    tests_run++;
    if (rd != int'(k) || exp_a_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s read_count: got %0d reads want %0d", name, rd, k);
    end
    tests_run++;
    if (hs != 4 || exp_row_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s handshakes: got %0d want 4", name, hs);
    end
    tests_run++;
    if (first_valid != int'(k) + done_delay + 4) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d want %0d", name, first_valid, int'(k) + done_delay + 4);
    end
    tests_run++;
    if (ready_bad != 0 || stray != 0) begin
      tests_failed++;
      $display("FAIL %s stray: got cmd_ready_busy=%0d stray_pulses=%0d want 0/0", name,
               ready_bad, stray);
    end
    exp_a_q.delete(); exp_b_q.delete(); exp_row_q.delete();

    if (!hold_next) begin
      @(negedge clk);
      tests_run++;
      if ({job_done, busy, cmd_ready} !== 3'b001) begin
        tests_failed++;
        $display("FAIL %s after_done: got done/busy/rdy=%b want 001", name,
                 {job_done, busy, cmd_ready});
      end
    end
  endtask

  task automatic test_basic();
    run_job("basic", 10'd8, 10'h010, 10'h020, 5, 16'h0000, 0, 1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_backpressure();
    run_job("backpressure", 10'd8, 10'h010, 10'h020, 5, 16'h0074, 7, 1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_addr_wrap();
    run_job("wrap", 10'd4, 10'h3FE, 10'h001, 0, 16'h0000, 0, 1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_err_cmd();
    int rd_seen;
    rd_seen = 0;
    cmd_valid = 1'b1; cmd_k = 10'd0; cmd_a_base = 10'h005; cmd_b_base = 10'h006;
    @(negedge clk);
    cmd_valid = 1'b0;
    tests_run++;
    if ({err_cmd, busy, cmd_ready, ndp_clear} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL err_cmd_pulse: got err/busy/rdy/clr=%b want 1010",
               {err_cmd, busy, cmd_ready, ndp_clear});
    end
    for (int i = 0; i < 4; i++) begin
      if (mem_rd_en || busy || ndp_clear) rd_seen++;
      @(negedge clk);
      if (i == 0) begin
        tests_run++;
        if (err_cmd !== 1'b0) begin
          tests_failed++;
          $display("FAIL err_cmd_width: got err_cmd=%b want 0 on second cycle", err_cmd);
        end
      end
    end
    tests_run++;
    if (rd_seen != 0) begin
      tests_failed++;
      $display("FAIL err_cmd_idle: got %0d active cycles want 0", rd_seen);
    end
  endtask

  task automatic test_timeout();
    int low, wait_cyc, rv, seen;
    bit stop;
    low = 0; wait_cyc = 0; rv = 0; seen = 0; stop = 1'b0;
    cmd_valid = 1'b1; cmd_k = 10'd2; cmd_a_base = 10'h000; cmd_b_base = 10'h000;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 100 && !stop; i++) begin
      @(negedge clk);
      if (!ndp_in_done_flag) low++;
      if (low > 0 && ndp_in_done_flag && busy) wait_cyc++;
      if (res_valid) rv++;
      if (err_timeout) begin
        seen++;
        stop = 1'b1;
        tests_run++;
        if ({busy, cmd_ready} !== 2'b01) begin
          tests_failed++;
          $display("FAIL timeout_idle: got busy/rdy=%b want 01", {busy, cmd_ready});
        end
      end
    end
    tests_run++;
    if (seen != 1 || wait_cyc != 16) begin
      tests_failed++;
      $display("FAIL timeout_len: got pulses=%0d wait_cycles=%0d want 1/16", seen, wait_cyc);
    end
    tests_run++;
    if (rv != 0 || low != 3) begin
      tests_failed++;
      $display("FAIL timeout_side: got res_valid_cycles=%0d feed_cycles=%0d want 0/3", rv, low);
    end
    @(negedge clk);
    tests_run++;
    if (err_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_width: got err_timeout=%b want 0", err_timeout);
    end
  endtask

  task automatic test_reset_mid_feed();
    bit found;
    int done_seen;
    found = 1'b0; done_seen = 0;
    cmd_valid = 1'b1; cmd_k = 10'd8; cmd_a_base = 10'h040; cmd_b_base = 10'h080;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_rd_en && mem_a_addr == 10'h043) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL reset_mid_beat3: got no beat 3 want a=043 within 20 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("reset_mid_feed");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (job_done || busy) done_seen++;
    end
    tests_run++;
    if (done_seen != 0) begin
      tests_failed++;
      $display("FAIL reset_abandon: got %0d busy/done cycles want 0", done_seen);
    end
    run_job("after_reset", 10'd2, 10'h100, 10'h200, 3, 16'h0000, 0, 1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_back_to_back();
    run_job("b2b_first", 10'd8, 10'h010, 10'h020, 5, 16'h0000, 0, 1'b1, 1'b1,
            10'd3, 10'h030, 10'h050);
    run_job("b2b_second", 10'd3, 10'h030, 10'h050, 2, 16'h0000, 0, 1'b0, 1'b0,
            '0, '0, '0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_k = '0; cmd_a_base = '0; cmd_b_base = '0;
    ndp_calc_done = 1'b0; res_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_addr_wrap();
    test_err_cmd();
    test_timeout();
    test_reset_mid_feed();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
